// File: rtl/shifter_rr_scheduler.sv
// Round-robin front end for one pipelined barrel shifter: grants one requester per cycle,
// carries the requester tag alongside the shifter pipeline and steers each result back.
module shifter_rr_scheduler #(
    parameter int NREQ   = 4,
    parameter int WIDTH  = 32,
    parameter int SHW    = 5,
    parameter int SH_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic [NREQ*SHW-1:0]   req_amt,
    input  logic [NREQ-1:0]       req_dir,
    output logic                  sh_valid_in,
    output logic [WIDTH-1:0]      sh_data_in,
    output logic [SHW-1:0]        sh_shift_amt,
    output logic                  sh_direction,
    input  logic                  sh_valid_out,
    input  logic [WIDTH-1:0]      sh_data_out,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  err
);
    localparam int TW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [TW-1:0]    rr_ptr;
    logic [TW-1:0]    gnt_idx;
    logic             gnt_any;
    logic [WIDTH-1:0] gnt_data;
    logic [SHW-1:0]   gnt_amt;
    logic             gnt_dir;
    logic [TW-1:0]    issue_tag;
    int               idx;

    logic             pipe_vld [SH_LAT];
    logic [TW-1:0]    pipe_tag [SH_LAT];
    logic             tail_vld;
    logic [TW-1:0]    tail_tag;

    // Walk offsets from the far end so the requester nearest rr_ptr wins.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        gnt_data = '0;
        gnt_amt  = '0;
        gnt_dir  = 1'b0;
        idx      = 0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            idx = (int'(rr_ptr) + off) % NREQ;
            if (req_valid[idx]) begin
                gnt_any  = 1'b1;
                gnt_idx  = TW'(idx);
                gnt_data = req_data[idx*WIDTH +: WIDTH];
                gnt_amt  = req_amt[idx*SHW +: SHW];
                gnt_dir  = req_dir[idx];
            end
        end
    end

    assign req_ready = (gnt_any && !rst) ? (NREQ'(1) << gnt_idx) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr       <= '0;
            issue_tag    <= '0;
            sh_valid_in  <= 1'b0;
            sh_data_in   <= '0;
            sh_shift_amt <= '0;
            sh_direction <= 1'b0;
        end else begin
            sh_valid_in <= gnt_any;
            if (gnt_any) begin
                rr_ptr       <= (gnt_idx == TW'(NREQ - 1)) ? '0 : gnt_idx + TW'(1);
                issue_tag    <= gnt_idx;
                sh_data_in   <= gnt_data;
                sh_shift_amt <= gnt_amt;
                sh_direction <= gnt_dir;
            end
        end
    end

    // Tag shadow of the shifter pipeline, loaded from what the shifter itself samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SH_LAT; s++) begin
                pipe_vld[s] <= 1'b0;
                pipe_tag[s] <= '0;
            end
        end else begin
            pipe_vld[0] <= sh_valid_in;
            pipe_tag[0] <= issue_tag;
            for (int s = 1; s < SH_LAT; s++) begin
                pipe_vld[s] <= pipe_vld[s-1];
                pipe_tag[s] <= pipe_tag[s-1];
            end
        end
    end

    assign tail_vld = pipe_vld[SH_LAT-1];
    assign tail_tag = pipe_tag[SH_LAT-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
            err       <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (sh_valid_out != tail_vld) begin
                err <= 1'b1;
            end else if (sh_valid_out) begin
                rsp_valid <= NREQ'(1) << tail_tag;
                rsp_data  <= sh_data_out;
            end
        end
    end
endmodule

// File: tb/tb_shifter_rr_scheduler.sv
// Bench for shifter_rr_scheduler: one-cycle shifter model, directed requests, response scoreboard.
module tb_shifter_rr_scheduler;
    localparam int NREQ = 4, WIDTH = 32, SHW = 5, SH_LAT = 1;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_data = '0;
    logic [NREQ*SHW-1:0]   req_amt = '0;
    logic [NREQ-1:0]       req_dir = '0;
    logic                  sh_valid_in;
    logic [WIDTH-1:0]      sh_data_in;
    logic [SHW-1:0]        sh_shift_amt;
    logic                  sh_direction;
    logic                  sh_valid_out;
    logic [WIDTH-1:0]      sh_data_out;
    logic [NREQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]      rsp_data;
    logic                  err;

    logic                  m_vld;
    logic [WIDTH-1:0]      m_dat;
    logic                  force_vld = 1'b0;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [NREQ-1:0]  vld;
        logic [WIDTH-1:0] dat;
    } exp_t;
    exp_t q[$];

    shifter_rr_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .SHW(SHW), .SH_LAT(SH_LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_amt(req_amt), .req_dir(req_dir),
        .sh_valid_in(sh_valid_in), .sh_data_in(sh_data_in),
        .sh_shift_amt(sh_shift_amt), .sh_direction(sh_direction),
        .sh_valid_out(sh_valid_out), .sh_data_out(sh_data_out),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural one-cycle logical barrel shifter
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_vld <= 1'b0;
            m_dat <= '0;
        end else begin
            m_vld <= sh_valid_in;
            m_dat <= sh_direction ? (sh_data_in >> sh_shift_amt) : (sh_data_in << sh_shift_amt);
        end
    end
    assign sh_valid_out = m_vld | force_vld;
    assign sh_data_out  = m_dat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [WIDTH-1:0] d, input logic [SHW-1:0] a, input logic dir);
        req_data[i*WIDTH +: WIDTH] = d;
        req_amt[i*SHW +: SHW]      = a;
        req_dir[i]                 = dir;
    endtask

    task automatic push(input logic [NREQ-1:0] v, input logic [WIDTH-1:0] d);
        exp_t e;
        e.vld = v;
        e.dat = d;
        q.push_back(e);
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 20 && q.size() != 0; c++) @(negedge clk);
        repeat (2) @(negedge clk);
        check(name, q.size(), 0);
    endtask

    // Monitor: every response strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && rsp_valid != '0) begin
            if (q.size() == 0) begin
                check("unexpected_rsp", rsp_valid, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("rsp_valid", rsp_valid, e.vld);
                check("rsp_data", rsp_data, e.dat);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("reset_sh_valid_in", sh_valid_in, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_err", err, 0);
        check("reset_req_ready", req_ready, 0);
        rst = 1'b0;

        // 1: req0 left by 2
        @(negedge clk);
        set_req(0, 32'hA5A5A5A5, 5'd2, 1'b0);
        req_valid = 4'b0001;
        #1 check("t1_grant", req_ready, 4'b0001);
        push(4'b0001, 32'h96969694);
        @(negedge clk);
        req_valid = '0;
        check("t1_issue_vld", sh_valid_in, 1);
        check("t1_issue_data", sh_data_in, 32'hA5A5A5A5);
        check("t1_issue_amt", sh_shift_amt, 2);
        check("t1_issue_dir", sh_direction, 0);
        @(negedge clk);
        check("t1_idle_vld", sh_valid_in, 0);
        check("t1_hold_data", sh_data_in, 32'hA5A5A5A5);
        drain("t1_drain");
        check("t1_err", err, 0);

        // 2: req2 right by 4, then amt 0 (rr_ptr passes over idle requesters)
        set_req(2, 32'hA5A5A5A5, 5'd4, 1'b1);
        req_valid = 4'b0100;
        #1 check("t2_grant_a", req_ready, 4'b0100);
        push(4'b0100, 32'h0A5A5A5A);
        @(negedge clk);
        set_req(2, 32'hA5A5A5A5, 5'd0, 1'b1);
        #1 check("t2_grant_b", req_ready, 4'b0100);
        push(4'b0100, 32'hA5A5A5A5);
        @(negedge clk);
        req_valid = '0;
        drain("t2_drain");

        // 3: all requesters from reset, right by 2
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 32'hA5A5A5A5, 5'd2, 1'b1);
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1 check("t3_grant", req_ready, 4'b0001 << (i % 4));
            push(4'b0001 << (i % 4), 32'h29696969);
            @(negedge clk);
        end
        req_valid = '0;
        drain("t3_drain");

        // 4: rr_ptr=1 -> grant req1 to move it to 2, then req1+req3 -> 3 then 1 (wrap)
        set_req(1, 32'h12345678, 5'd8, 1'b0);
        set_req(3, 32'h80000001, 5'd31, 1'b1);
        req_valid = 4'b0010;
        #1 check("t4_setup_grant", req_ready, 4'b0010);
        push(4'b0010, 32'h34567800);
        @(negedge clk);
        req_valid = 4'b1010;
        #1 check("t4_grant_3", req_ready, 4'b1000);
        push(4'b1000, 32'h00000001);
        @(negedge clk);
        #1 check("t4_grant_1", req_ready, 4'b0010);
        push(4'b0010, 32'h34567800);
        @(negedge clk);
        req_valid = '0;
        #1 check("t4_no_grant", req_ready, 4'b0000);
        drain("t4_drain");

        // 5: spurious shifter valid with empty tag pipeline
        force_vld = 1'b1;
        @(negedge clk);
        force_vld = 1'b0;
        check("t5_err_set", err, 1);
        check("t5_no_rsp", rsp_valid, 0);
        repeat (3) @(negedge clk);
        check("t5_err_sticky", err, 1);
        rst = 1'b1;
        #1 check("t5_err_cleared", err, 0);
        @(negedge clk);
        rst = 1'b0;

        // 6: reset one cycle after a grant drops the op
        set_req(0, 32'hFFFF0000, 5'd16, 1'b1);
        req_valid = 4'b0001;
        #1 check("t6_grant", req_ready, 4'b0001);
        @(negedge clk);
        req_valid = '0;
        rst = 1'b1;
        #1;
        check("t6_rst_sh_valid_in", sh_valid_in, 0);
        check("t6_rst_sh_data_in", sh_data_in, 0);
        check("t6_rst_rsp_valid", rsp_valid, 0);
        check("t6_rst_rsp_data", rsp_data, 0);
        check("t6_rst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        set_req(2, 32'hFFFF0000, 5'd16, 1'b1);
        req_valid = 4'b0100;
        #1 check("t6_fresh_grant", req_ready, 4'b0100);
        push(4'b0100, 32'h0000FFFF);
        @(negedge clk);
        req_valid = '0;
        drain("t6_drain");
        check("t6_err", err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
